// File: rtl/regbit_pkg.sv
// Shared register-file constants: word width, bit-slice bounds, reset value and a parity helper
// used when building multi-bit registers out of regbit instances.
package regbit_pkg;

    localparam int unsigned REG_W         = 8;
    localparam int unsigned REG_LSB       = 0;
    localparam int unsigned REG_MSB       = REG_W - 1;
    localparam logic        REG_RESET_VAL = 1'b0;

    function automatic logic reg_parity(input logic [REG_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/regbit_if.sv
// Data/control bundle of one register-file storage bit: the datapath drives d/ld,
// the storage bit returns true and complement outputs.
interface regbit_if;

    logic d;
    logic ld;
    logic q;
    logic nq;

    modport master (output d, output ld, input q, input nq);
    modport slave  (input d, input ld, output q, output nq);

endinterface

// File: rtl/regbit_chk.sv
// Simulation-only companion for regbit: flags a two-phase clock pair that is not complementary.
// It is instantiated next to the storage bits, never inside them, so it stays out of the netlist.
module regbit_chk (
    input logic clk,
    input logic rst_n,
    input logic cclk
);

    a_cclk_complement: assert property (@(posedge clk) disable iff (!rst_n) cclk != clk)
        else $error("regbit_chk: cclk equals clk outside reset");

endmodule

// File: rtl/regbit.sv
// One storage bit of the CPU register file: load-enabled capture on rising clk,
// asynchronous active-low reset, true and complement outputs.
module regbit
    import regbit_pkg::*;
#(
    parameter logic RESET_VAL = REG_RESET_VAL
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     cclk,
    regbit_if.slave  bus
);

    logic q_q;
    logic q_d;
    logic cclk_unused_s;

    // The second clock phase is kept only so the two-phase netlist still connects.
    assign cclk_unused_s = cclk;

    // Next-state mux; the d&q consensus term keeps an unknown ld from corrupting q when d already matches.
    always_comb begin
        q_d = (bus.ld & bus.d) | (~bus.ld & q_q) | (bus.d & q_q);
    end

    // Storage flop with asynchronous reset to RESET_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q  = q_q;
    assign bus.nq = ~q_q;

endmodule

// File: tb/tb_regbit.sv
// Directed self-checking bench for regbit: eight instances form a byte, bit 0 doubles as the single-bit view.
module tb_regbit;
    import regbit_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             cclk;
    logic             ld_s;
    logic [REG_W-1:0] d_vec;
    logic [REG_W-1:0] q_vec;
    logic [REG_W-1:0] nq_vec;

    int checks   = 0;
    int failures = 0;

    assign cclk = ~clk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < REG_W; i++) begin : g_bit
        regbit_if bif ();
        assign bif.d     = d_vec[i];
        assign bif.ld    = ld_s;
        assign q_vec[i]  = bif.q;
        assign nq_vec[i] = bif.nq;
        regbit #(.RESET_VAL(1'b0)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .cclk  (cclk),
            .bus   (bif)
        );
    end

    regbit_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .cclk  (cclk)
    );

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_s  = 1'b0;
        d_vec = 8'h00;
        #2;
        checks++;
        if (q_vec !== 8'h00 || nq_vec !== 8'hFF) begin
            $display("FAIL reset_initial q=%h nq=%h expected q=00 nq=ff", q_vec, nq_vec);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        d_vec = 8'hFF;
        ld_s  = 1'b1;
        edge_sample();
        checks++;
        if (q_vec !== 8'hFF) begin
            $display("FAIL reset_preload q=%h expected ff", q_vec);
            failures++;
        end
        ld_s = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q_vec !== 8'h00 || nq_vec !== 8'hFF) begin
            $display("FAIL reset_async q=%h nq=%h expected q=00 nq=ff", q_vec, nq_vec);
            failures++;
        end
        ld_s = 1'b1;
        edge_sample();
        edge_sample();
        checks++;
        if (q_vec !== 8'h00) begin
            $display("FAIL reset_hold q=%h expected 00", q_vec);
            failures++;
        end
        @(negedge clk);
        ld_s  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_keep();
        @(negedge clk);
        d_vec = 8'h00;
        ld_s  = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (n == 2) begin
                @(negedge clk);
                d_vec = 8'hFF;
            end
            edge_sample();
            checks++;
            if (q_vec !== 8'h00 || nq_vec !== 8'hFF) begin
                $display("FAIL keep_cycle%0d q=%h nq=%h expected q=00 nq=ff", n, q_vec, nq_vec);
                failures++;
            end
        end
    endtask

    task automatic test_load1();
        @(negedge clk);
        d_vec = 8'hFF;
        ld_s  = 1'b1;
        #4;
        checks++;
        if (q_vec !== 8'h00) begin
            $display("FAIL load1_before_edge q=%h expected 00", q_vec);
            failures++;
        end
        edge_sample();
        checks++;
        if (q_vec !== 8'hFF || nq_vec !== 8'h00) begin
            $display("FAIL load1_capture q=%h nq=%h expected q=ff nq=00", q_vec, nq_vec);
            failures++;
        end
        @(negedge clk);
        ld_s  = 1'b0;
        d_vec = 8'h00;
        edge_sample();
        edge_sample();
        checks++;
        if (q_vec !== 8'hFF || nq_vec !== 8'h00) begin
            $display("FAIL load1_hold q=%h nq=%h expected q=ff nq=00", q_vec, nq_vec);
            failures++;
        end
    endtask

    task automatic test_load0();
        @(negedge clk);
        d_vec = 8'h00;
        ld_s  = 1'b1;
        edge_sample();
        checks++;
        if (q_vec !== 8'h00 || nq_vec !== 8'hFF) begin
            $display("FAIL load0_capture q=%h nq=%h expected q=00 nq=ff", q_vec, nq_vec);
            failures++;
        end
        @(negedge clk);
        ld_s  = 1'b0;
        d_vec = 8'hFF;
        edge_sample();
        checks++;
        if (q_vec !== 8'h00) begin
            $display("FAIL load0_hold q=%h expected 00", q_vec);
            failures++;
        end
    endtask

    task automatic test_ld_unknown();
        @(negedge clk);
        d_vec = 8'h00;
        ld_s  = 1'bx;
        edge_sample();
        checks++;
        if (q_vec !== 8'h00) begin
            $display("FAIL ld_x_no_prop q=%h expected 00", q_vec);
            failures++;
        end
        @(negedge clk);
        ld_s = 1'b0;
    endtask

    task automatic test_array();
        @(negedge clk);
        d_vec = 8'hAA;
        ld_s  = 1'b1;
        edge_sample();
        checks++;
        if (q_vec !== 8'hAA || nq_vec !== 8'h55) begin
            $display("FAIL array_aa q=%h nq=%h expected q=aa nq=55", q_vec, nq_vec);
            failures++;
        end
        checks++;
        if (reg_parity(q_vec) !== 1'b0) begin
            $display("FAIL array_parity got=%b expected 0", reg_parity(q_vec));
            failures++;
        end
        @(negedge clk);
        d_vec = 8'h55;
        edge_sample();
        checks++;
        if (q_vec !== 8'h55 || nq_vec !== 8'hAA) begin
            $display("FAIL array_55 q=%h nq=%h expected q=55 nq=aa", q_vec, nq_vec);
            failures++;
        end
        @(negedge clk);
        ld_s = 1'b0;
    endtask

    task automatic test_glitch();
        @(posedge clk);
        d_vec = 8'hFF;
        #2;
        ld_s = 1'b1;
        #2;
        ld_s = 1'b0;
        edge_sample();
        checks++;
        if (q_vec !== 8'h55 || nq_vec !== 8'hAA) begin
            $display("FAIL glitch_ignored q=%h nq=%h expected q=55 nq=aa", q_vec, nq_vec);
            failures++;
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        d_vec = 8'hFF;
        ld_s  = 1'b1;
        #2;
        rst_n = 1'b0;
        edge_sample();
        checks++;
        if (q_vec !== 8'h00 || nq_vec !== 8'hFF) begin
            $display("FAIL rst_mid_load q=%h nq=%h expected q=00 nq=ff", q_vec, nq_vec);
            failures++;
        end
        @(negedge clk);
        ld_s  = 1'b0;
        rst_n = 1'b1;
        edge_sample();
        edge_sample();
        checks++;
        if (q_vec !== 8'h00) begin
            $display("FAIL rst_release_hold q=%h expected 00", q_vec);
            failures++;
        end
        @(negedge clk);
        d_vec = 8'h3C;
        ld_s  = 1'b1;
        edge_sample();
        checks++;
        if (q_vec !== 8'h3C || nq_vec !== 8'hC3) begin
            $display("FAIL rst_then_load q=%h nq=%h expected q=3c nq=c3", q_vec, nq_vec);
            failures++;
        end
        @(negedge clk);
        ld_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_keep();
        test_load1();
        test_load0();
        test_ld_unknown();
        test_array();
        test_glitch();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
